// File: rtl/instruction_fetch_if.sv
// Fetch-unit bundle: instruction memory port plus consumer-side
// stream, stall and redirect signals.
interface instruction_fetch_if;
    logic [10:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [10:0] redirect_addr;
    logic [31:0] instr_out;
    logic [10:0] pc_out;
    logic        instr_valid;
    logic        halted;
    logic [15:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  redirect_valid,
        input  redirect_addr,
        output instr_out,
        output pc_out,
        output instr_valid,
        output halted,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output redirect_valid,
        output redirect_addr,
        input  instr_out,
        input  pc_out,
        input  instr_valid,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: sequential word fetch from a 1-cycle memory with
// stall hold, branch redirect, halt-word detection and accept counter.
module instruction_fetch #(
    parameter logic [10:0] RESET_PC  = 11'd0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_fetch_if.master fif
);
    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_n;
    logic [10:0] fetch_pc, fetch_pc_n;
    logic [10:0] resp_pc, resp_pc_n;
    logic        resp_valid, resp_valid_n;
    logic [15:0] count, count_n;
    logic        accept;
    logic        hold;
    logic        is_halt;
    logic        redir;

    assign accept  = resp_valid && !fif.stall && (state == RUN);
    assign hold    = resp_valid && fif.stall && !fif.redirect_valid;
    assign is_halt = accept && (fif.imem_data == HALT_WORD);
    assign redir   = fif.redirect_valid && !is_halt;

    // Re-read the held address so imem_data stays stable under stall.
    assign fif.imem_addr   = hold ? resp_pc : fetch_pc;
    assign fif.instr_out   = fif.imem_data;
    assign fif.pc_out      = resp_pc;
    assign fif.instr_valid = resp_valid;
    assign fif.halted      = (state == HALT);
    assign fif.fetch_count = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC;
            resp_pc    <= RESET_PC;
            resp_valid <= 1'b0;
            count      <= 16'd0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            resp_pc    <= resp_pc_n;
            resp_valid <= resp_valid_n;
            count      <= count_n;
        end
    end

    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        resp_pc_n    = resp_pc;
        resp_valid_n = resp_valid;
        count_n      = count;

        if (accept && count != 16'hFFFF)
            count_n = count + 16'd1;

        if (state == RUN) begin
            unique case (1'b1)
                is_halt: begin
                    state_n      = HALT;
                    resp_valid_n = 1'b0;
                end
                redir: begin
                    fetch_pc_n   = fif.redirect_addr;
                    resp_valid_n = 1'b0;
                end
                hold: begin
                    resp_valid_n = 1'b1;
                end
                default: begin
                    resp_pc_n    = fetch_pc;
                    resp_valid_n = 1'b1;
                    fetch_pc_n   = fetch_pc + 11'd1;
                end
            endcase
        end else begin
            resp_valid_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model, accept scoreboard,
// per-cycle vector table and directed stall/halt/reset sequences.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    instruction_fetch_if fif();

    instruction_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [2048];

    always @(posedge clk) fif.imem_data <= mem[fif.imem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] sb_q [$];
    bit          sb_en = 1'b0;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [10:0] ra;
        logic        ev;
        logic [10:0] epc;
        logic [10:0] eaddr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted instruction must match the next pushed pc.
    always @(negedge clk) begin
        if (sb_en && fif.instr_valid && !fif.stall && !fif.halted) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pc", {21'd0, fif.pc_out}, 32'hFFFF);
            end else begin
                logic [10:0] e;
                e = sb_q.pop_front();
                chk("sb_pc", {21'd0, fif.pc_out}, {21'd0, e});
                chk("sb_instr", fif.instr_out, mem[e]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        chk("sb_drained", sb_q.size(), 0);
        sb_q.delete();
        rst_n = 1'b0;
        fif.stall = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.redirect_addr = 11'd0;
        step();
        step();
        rst_n = 1'b1;
        sb_en = 1'b1;
    endtask

    task automatic run_until_pc(input logic [10:0] t);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            hit = fif.instr_valid && (fif.pc_out == t);
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL run_until_pc: pc %0d not reached, got %0d",
                     t, fif.pc_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = i;
        fif.stall = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.redirect_addr = 11'd0;

        //         stall rv  ra    ev  epc   eaddr  ecnt
        vecs[0]  = '{1'b0, 1'b1, 11'd100,  1'b1, 11'd7,    11'd8,    16'd7};
        vecs[1]  = '{1'b0, 1'b0, 11'd0,    1'b0, 11'd0,    11'd100,  16'd8};
        vecs[2]  = '{1'b0, 1'b0, 11'd0,    1'b1, 11'd100,  11'd101,  16'd8};
        vecs[3]  = '{1'b0, 1'b1, 11'd2046, 1'b1, 11'd101,  11'd102,  16'd9};
        vecs[4]  = '{1'b0, 1'b0, 11'd0,    1'b0, 11'd0,    11'd2046, 16'd10};
        vecs[5]  = '{1'b0, 1'b0, 11'd0,    1'b1, 11'd2046, 11'd2047, 16'd10};
        vecs[6]  = '{1'b0, 1'b0, 11'd0,    1'b1, 11'd2047, 11'd0,    16'd11};
        vecs[7]  = '{1'b0, 1'b0, 11'd0,    1'b1, 11'd0,    11'd1,    16'd12};
        vecs[8]  = '{1'b0, 1'b0, 11'd0,    1'b1, 11'd1,    11'd2,    16'd13};
        vecs[9]  = '{1'b1, 1'b0, 11'd0,    1'b1, 11'd2,    11'd2,    16'd14};
        vecs[10] = '{1'b1, 1'b1, 11'd50,   1'b1, 11'd2,    11'd3,    16'd14};
        vecs[11] = '{1'b0, 1'b0, 11'd0,    1'b0, 11'd0,    11'd50,   16'd14};
        vecs[12] = '{1'b1, 1'b0, 11'd0,    1'b1, 11'd50,   11'd50,   16'd14};

        // Reset state and free-running stream
        do_reset();
        @(negedge clk);
        chk("rst_valid", fif.instr_valid, 0);
        chk("rst_halted", fif.halted, 0);
        chk("rst_count", fif.fetch_count, 0);
        chk("rst_addr", fif.imem_addr, 0);
        for (int i = 0; i < 10; i++) sb_q.push_back(i[10:0]);
        run_until_pc(11'd10);
        fif.stall = 1'b1;
        @(negedge clk);
        chk("stream_count", fif.fetch_count, 10);
        chk("stream_instr", fif.instr_out, 10);

        // Stall hold at pc 5
        do_reset();
        for (int i = 0; i < 5; i++) sb_q.push_back(i[10:0]);
        run_until_pc(11'd5);
        fif.stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_addr", fif.imem_addr, 5);
            chk("hold_pc", fif.pc_out, 5);
            chk("hold_instr", fif.instr_out, 5);
            chk("hold_count", fif.fetch_count, 5);
            step();
        end
        fif.stall = 1'b0;
        sb_q.push_back(11'd5);
        step();
        fif.stall = 1'b1;
        @(negedge clk);
        chk("post_stall_pc", fif.pc_out, 6);
        chk("post_stall_count", fif.fetch_count, 6);

        // Redirect, wrap and stall-dropped redirect from the vector table
        do_reset();
        for (int i = 0; i < 7; i++) sb_q.push_back(i[10:0]);
        run_until_pc(11'd7);
        for (int i = 0; i < 13; i++) begin
            fif.stall = vecs[i].stall;
            fif.redirect_valid = vecs[i].rv;
            fif.redirect_addr = vecs[i].ra;
            if (vecs[i].ev && !vecs[i].stall) sb_q.push_back(vecs[i].epc);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), fif.instr_valid, vecs[i].ev);
            if (vecs[i].ev)
                chk($sformatf("vec%0d_pc", i), fif.pc_out, vecs[i].epc);
            chk($sformatf("vec%0d_addr", i), fif.imem_addr, vecs[i].eaddr);
            chk($sformatf("vec%0d_count", i), fif.fetch_count, vecs[i].ecnt);
            step();
        end
        fif.redirect_valid = 1'b0;

        // Halt word at address 3, redirect ignored, reset restarts
        mem[3] = 32'hFFFF_FFFF;
        do_reset();
        for (int i = 0; i < 4; i++) sb_q.push_back(i[10:0]);
        for (int i = 0; i < 20 && !fif.halted; i++) step();
        @(negedge clk);
        chk("halt_flag", fif.halted, 1);
        chk("halt_valid", fif.instr_valid, 0);
        chk("halt_count", fif.fetch_count, 4);
        step();
        fif.redirect_valid = 1'b1;
        fif.redirect_addr = 11'd100;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("halt_redir_flag", fif.halted, 1);
            chk("halt_redir_valid", fif.instr_valid, 0);
            chk("halt_redir_count", fif.fetch_count, 4);
            chk("halt_redir_addr", fif.imem_addr, 4);
            step();
        end
        fif.redirect_valid = 1'b0;
        mem[3] = 32'd3;
        sb_en = 1'b0;
        chk("halt_sb_drained", sb_q.size(), 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_halted", fif.halted, 0);
        chk("restart_count", fif.fetch_count, 0);
        chk("restart_valid", fif.instr_valid, 0);
        chk("restart_addr", fif.imem_addr, 0);
        sb_q.push_back(11'd0);
        sb_en = 1'b1;
        step();
        @(negedge clk);
        chk("restart_first_valid", fif.instr_valid, 1);
        chk("restart_first_pc", fif.pc_out, 0);
        step();
        fif.stall = 1'b1;

        // Reset during stall-hold at pc 20
        do_reset();
        for (int i = 0; i < 20; i++) sb_q.push_back(i[10:0]);
        run_until_pc(11'd20);
        fif.stall = 1'b1;
        @(negedge clk);
        chk("s20_addr", fif.imem_addr, 20);
        chk("s20_count", fif.fetch_count, 20);
        step();
        @(negedge clk);
        chk("s20_hold_pc", fif.pc_out, 20);
        chk("s20_hold_instr", fif.instr_out, 20);
        step();
        sb_en = 1'b0;
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("s20_rst_valid", fif.instr_valid, 0);
        chk("s20_rst_addr", fif.imem_addr, 0);
        chk("s20_rst_count", fif.fetch_count, 0);
        chk("s20_rst_halted", fif.halted, 0);
        step();
        rst_n = 1'b1;
        fif.stall = 1'b0;
        chk("final_sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
